// File: rtl/mont_exp_ctrl_pkg.sv
// Shared types and defaults for the Montgomery exponentiation controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mont_exp_ctrl_pkg;

   localparam int N_DEF   = 1024;
   localparam int E_W_DEF = 1024;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_SQR_REQ  = 3'd2,
      ST_SQR_WAIT = 3'd3,
      ST_MUL_REQ  = 3'd4,
      ST_MUL_WAIT = 3'd5,
      ST_FIN      = 3'd6
   } state_t;

   // Width of the exponent bit index; never narrower than one bit.
   function automatic int idx_width(input int e_w);
      return (e_w > 1) ? $clog2(e_w) : 1;
   endfunction

endpackage

// File: rtl/mont_exp_ctrl_scanner.sv
// Exponent bit scanner: holds E and walks its bits MSB first.
// Latency: load/step take effect on the next clock edge; outputs decode the held state.
// Backpressure: none; the controller only steps when the current bit has been consumed.
module mont_exp_ctrl_scanner
   import mont_exp_ctrl_pkg::*;
#(
   parameter int E_W = E_W_DEF
)
(
   input  logic           clk,
   input  logic           resetn,
   input  logic           load,
   input  logic [E_W-1:0] e_in,
   input  logic           step,
   output logic           cur_bit,
   output logic           last,
   output logic           e_zero
);

   localparam int               IDX_W   = idx_width(E_W);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(E_W - 1);

   logic [E_W-1:0]   e_q, e_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   // Load a fresh exponent at the MSB, or move one bit toward the LSB.
   // The controller never steps at idx 0, so the counter cannot wrap.
   always_comb begin
      e_d   = e_q;
      idx_d = idx_q;
      if (load) begin
         e_d   = e_in;
         idx_d = IDX_TOP;
      end else if (step) begin
         idx_d = idx_q - 1'b1;
      end
   end

   // Scanner state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         e_q   <= '0;
         idx_q <= '0;
      end else begin
         e_q   <= e_d;
         idx_q <= idx_d;
      end
   end

   assign cur_bit = e_q[idx_q];
   assign last    = (idx_q == '0);
   assign e_zero  = (e_q == '0);

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external Montgomery multiplier.
// Latency: start to done = 3 + sum over MM requests of (multiplier latency + 1) cycles.
// Backpressure: one MM request outstanding at a time; waits for mm_done; start ignored while busy.
module mont_exp_ctrl
   import mont_exp_ctrl_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int E_W = E_W_DEF
)
(
   input  logic           clk,
   input  logic           resetn,
   input  logic           start,
   input  logic [N-1:0]   in_x,
   input  logic [E_W-1:0] in_e,
   input  logic [N-1:0]   in_m,
   input  logic [N-1:0]   in_r,
   output logic [N-1:0]   result,
   output logic           done,
   output logic           busy,
   output logic           mm_start,
   output logic [N-1:0]   mm_a,
   output logic [N-1:0]   mm_b,
   output logic [N-1:0]   mm_m,
   input  logic [N:0]     mm_result,
   input  logic           mm_done
);

   state_t         state_q, state_d;
   logic [N-1:0]   x_q, x_d;
   logic [N-1:0]   acc_q, acc_d;
   logic [N-1:0]   result_q, result_d;
   logic [N-1:0]   mm_a_q, mm_a_d;
   logic [N-1:0]   mm_b_q, mm_b_d;
   logic [N-1:0]   mm_m_q, mm_m_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic           mm_start_q, mm_start_d;

   logic           sc_load, sc_step;
   logic           sc_bit, sc_last, sc_zero;
   logic [N-1:0]   mm_res;

   // The multiplier result is already reduced below M, so its top bit carries nothing.
   logic           unused_mm_msb;
   assign unused_mm_msb = mm_result[N];
   assign mm_res        = mm_result[N-1:0];

   mont_exp_ctrl_scanner #(
      .E_W     (E_W)
   ) u_scanner (
      .clk     (clk),
      .resetn  (resetn),
      .load    (sc_load),
      .e_in    (in_e),
      .step    (sc_step),
      .cur_bit (sc_bit),
      .last    (sc_last),
      .e_zero  (sc_zero)
   );

   // Next-state logic. Operands and mm_start are set on the edge entering a REQ state,
   // so the request pulse and its operands appear together during the REQ cycle and
   // the operands stay put until the WAIT state consumes mm_done.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      acc_d      = acc_q;
      result_d   = result_q;
      mm_a_d     = mm_a_q;
      mm_b_d     = mm_b_q;
      mm_m_d     = mm_m_q;
      done_d     = 1'b0;
      busy_d     = busy_q;
      mm_start_d = 1'b0;
      sc_load    = 1'b0;
      sc_step    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_d     = in_x;
               mm_m_d  = in_m;
               acc_d   = in_r;
               sc_load = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (sc_zero) begin
               state_d = ST_FIN;
            end else begin
               mm_a_d     = acc_q;
               mm_b_d     = acc_q;
               mm_start_d = 1'b1;
               state_d    = ST_SQR_REQ;
            end
         end

         ST_SQR_REQ: state_d = ST_SQR_WAIT;

         ST_SQR_WAIT: begin
            if (mm_done) begin
               acc_d = mm_res;
               if (sc_bit) begin
                  mm_a_d     = mm_res;
                  mm_b_d     = x_q;
                  mm_start_d = 1'b1;
                  state_d    = ST_MUL_REQ;
               end else if (sc_last) begin
                  state_d = ST_FIN;
               end else begin
                  sc_step    = 1'b1;
                  mm_a_d     = mm_res;
                  mm_b_d     = mm_res;
                  mm_start_d = 1'b1;
                  state_d    = ST_SQR_REQ;
               end
            end
         end

         ST_MUL_REQ: state_d = ST_MUL_WAIT;

         ST_MUL_WAIT: begin
            if (mm_done) begin
               acc_d = mm_res;
               if (sc_last) begin
                  state_d = ST_FIN;
               end else begin
                  sc_step    = 1'b1;
                  mm_a_d     = mm_res;
                  mm_b_d     = mm_res;
                  mm_start_d = 1'b1;
                  state_d    = ST_SQR_REQ;
               end
            end
         end

         ST_FIN: begin
            result_d = acc_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         x_q        <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         mm_a_q     <= '0;
         mm_b_q     <= '0;
         mm_m_q     <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         mm_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         mm_a_q     <= mm_a_d;
         mm_b_q     <= mm_b_d;
         mm_m_q     <= mm_m_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         mm_start_q <= mm_start_d;
      end
   end

   assign result   = result_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign mm_start = mm_start_q;
   assign mm_a     = mm_a_q;
   assign mm_b     = mm_b_q;
   assign mm_m     = mm_m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl with N=8, E_W=4, M=13, R mod M = 9, R^-1 mod M = 3.
// Latency: behavioural multiplier answers a*b*R^-1 mod M after a fixed or random delay.
// Backpressure: one request outstanding; mm_done is pulsed for one cycle per request.
module tb_mont_exp_ctrl;

   localparam int N    = 8;
   localparam int E_W  = 4;
   localparam int M    = 13;
   localparam int RMOD = 9;
   localparam int RINV = 3;

   logic           clk = 1'b0;
   logic           resetn;
   logic           start;
   logic [N-1:0]   in_x, in_m, in_r;
   logic [E_W-1:0] in_e;
   logic [N-1:0]   result;
   logic           done, busy, mm_start;
   logic [N-1:0]   mm_a, mm_b, mm_m;
   logic [N:0]     mm_result;
   logic           resp_done, inj_done;
   logic           mm_done;

   assign mm_done = resp_done | inj_done;

   always #5 clk = ~clk;

   mont_exp_ctrl #(
      .N         (N),
      .E_W       (E_W)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .in_x      (in_x),
      .in_e      (in_e),
      .in_m      (in_m),
      .in_r      (in_r),
      .result    (result),
      .done      (done),
      .busy      (busy),
      .mm_start  (mm_start),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_m      (mm_m),
      .mm_result (mm_result),
      .mm_done   (mm_done)
   );

   int checks   = 0;
   int failures = 0;

   // Multiplier model state, written only by the responder process.
   int lat_fixed    = 5;
   int mm_start_cnt = 0;
   int stab_cnt     = 0;
   int stab_bad     = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Behavioural Montgomery multiplier: latches a request in its mm_start cycle,
   // watches the operands while it is busy and answers after the chosen latency.
   initial begin
      logic [N-1:0] ca, cb, cm;
      int           lat;
      int           prod;
      bit           aborted;
      resp_done = 1'b0;
      mm_result = '0;
      forever begin
         @(posedge clk); #1;
         resp_done = 1'b0;
         if (resetn === 1'b1 && mm_start === 1'b1) begin
            mm_start_cnt++;
            ca      = mm_a;
            cb      = mm_b;
            cm      = mm_m;
            lat     = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(20, 1));
            aborted = 1'b0;
            for (int k = 1; k <= lat; k++) begin
               @(posedge clk); #1;
               if (!resetn) begin
                  aborted = 1'b1;
                  break;
               end
               stab_cnt++;
               if (mm_a !== ca || mm_b !== cb || mm_m !== cm || mm_start !== 1'b0)
                  stab_bad++;
            end
            if (!aborted) begin
               prod      = (int'(ca) * int'(cb) * RINV) % M;
               mm_result = prod[N:0];
               resp_done = 1'b1;
            end
         end
      end
   end

   typedef struct {
      logic [N-1:0]   x;
      logic [E_W-1:0] e;
      logic [N-1:0]   res;
      int             pulses;
      int             lat;
   } vec_t;

   vec_t vecs[6];

   // One exponentiation: pulse start, scramble the inputs, wait for done and check.
   // disturb adds a spurious mm_done in the SQR_REQ cycle and a second start while busy.
   task automatic run_vec(input vec_t v, input bit disturb, input bit chk_lat);
      int cnt0;
      int cyc;
      bit seen_done;
      @(posedge clk); #1;
      in_x  = v.x;
      in_e  = v.e;
      in_m  = N'(M);
      in_r  = N'(RMOD);
      start = 1'b1;
      cnt0      = mm_start_cnt;
      cyc       = 0;
      seen_done = 1'b0;
      while (cyc < 3000 && !seen_done) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            in_x  = 8'hAA;
            in_e  = 4'b1010;
            in_m  = 8'd7;
            in_r  = 8'd1;
            chk("busy_after_start", int'(busy), 1);
         end
         if (disturb) begin
            if (cyc == 2) inj_done = 1'b1;
            if (cyc == 3) inj_done = 1'b0;
            if (cyc == 5) begin
               start = 1'b1;
               in_x  = 8'd9;
               in_e  = 4'b1111;
            end
            if (cyc == 6) start = 1'b0;
         end
         if (done === 1'b1) seen_done = 1'b1;
      end
      chk("done_seen", int'(seen_done), 1);
      if (chk_lat) chk("latency", cyc, v.lat);
      chk("result", int'(result), int'(v.res));
      chk("mm_start_pulses", mm_start_cnt - cnt0, v.pulses);
      chk("busy_low_at_done", int'(busy), 0);
      chk("mm_m_registered", int'(mm_m), M);
      @(posedge clk); #1;
      chk("done_one_cycle", int'(done), 0);
      chk("result_held", int'(result), int'(v.res));
   endtask

   initial begin
      int cnt0;
      int waited;
      resetn   = 1'b0;
      start    = 1'b0;
      in_x     = '0;
      in_e     = '0;
      in_m     = '0;
      in_r     = '0;
      inj_done = 1'b0;

      // x=5 is Mont(2), x=9 is Mont(1), x=1 is Mont(3); results are Mont forms.
      vecs[0] = '{x: 8'd5, e: 4'b0101, res: 8'd2, pulses: 6, lat: 39};
      vecs[1] = '{x: 8'd5, e: 4'b0000, res: 8'd9, pulses: 0, lat: 3};
      vecs[2] = '{x: 8'd5, e: 4'b1111, res: 8'd7, pulses: 8, lat: 51};
      vecs[3] = '{x: 8'd5, e: 4'b0001, res: 8'd5, pulses: 5, lat: 33};
      vecs[4] = '{x: 8'd5, e: 4'b1000, res: 8'd3, pulses: 5, lat: 33};
      vecs[5] = '{x: 8'd1, e: 4'b0010, res: 8'd3, pulses: 5, lat: 33};

      #12;
      chk("reset_result", int'(result), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_mm_start", int'(mm_start), 0);
      chk("reset_mm_a", int'(mm_a), 0);
      chk("reset_mm_b", int'(mm_b), 0);
      chk("reset_mm_m", int'(mm_m), 0);
      @(negedge clk);
      resetn = 1'b1;

      // Directed vectors with fixed multiplier latency 5.
      for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, 1'b1);

      // Spurious mm_done in SQR_REQ and a restart while busy must change nothing.
      run_vec(vecs[0], 1'b1, 1'b1);

      // Reset while the first multiply is outstanding.
      @(posedge clk); #1;
      cnt0  = mm_start_cnt;
      in_x  = vecs[0].x;
      in_e  = vecs[0].e;
      in_m  = N'(M);
      in_r  = N'(RMOD);
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      waited = 0;
      while (mm_start_cnt < cnt0 + 3 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      chk("reached_mul_wait", int'(mm_start_cnt >= cnt0 + 3), 1);
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("abort_result", int'(result), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_mm_start", int'(mm_start), 0);
      chk("abort_mm_a", int'(mm_a), 0);
      chk("abort_mm_b", int'(mm_b), 0);
      chk("abort_mm_m", int'(mm_m), 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      inj_done = 1'b1;
      @(posedge clk); #1;
      inj_done = 1'b0;
      cnt0 = mm_start_cnt;
      repeat (10) @(posedge clk);
      #1;
      chk("no_request_after_abort", mm_start_cnt - cnt0, 0);
      chk("idle_after_abort_busy", int'(busy), 0);
      chk("idle_after_abort_done", int'(done), 0);
      run_vec(vecs[0], 1'b0, 1'b1);

      // Random multiplier latency 1..20; operands must hold for each request.
      lat_fixed = 0;
      run_vec(vecs[0], 1'b0, 1'b0);
      run_vec(vecs[2], 1'b0, 1'b0);
      run_vec(vecs[5], 1'b0, 1'b0);
      chk("stability_samples_seen", int'(stab_cnt > 0), 1);
      chk("operand_stability_violations", stab_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
